dvi_iic_responder: RTL and testbench

DVI_IIC_RESPONDER -- requirements
Module: dvi_iic_responder

---
 rtl/dvi_pkg.sv | 7 +
 rtl/iic_line_sync.sv | 36 +++
 rtl/dvi_iic_responder.sv | 145 ++++++++++++++
 tb/tb_dvi_iic_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// dvi_pkg: shared types and constants for the DVI encoder control-bus responder.
package dvi_pkg;
  localparam logic [6:0] CH7301_ADDR = 7'h76;
  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEVACK, REGADDR, REGACK, WRDATA, WRACK, RDDATA, RDACK
  } iic_state_e;
endpackage

// File: rtl/iic_line_sync.sv
// iic_line_sync: synchronizes SCL/SDA into the Clk domain and flags edges, START and STOP.
module iic_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  // Top bit of each vector is the previous synchronized value used for edge detection.
  logic [SYNC_STAGES:0] scl_q, sda_q;
  logic scl_s, scl_p, sda_s, sda_p;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-1:0], scl_i};
      sda_q <= {sda_q[SYNC_STAGES-1:0], sda_i};
    end
  end
  assign scl_s      = scl_q[SYNC_STAGES-1];
  assign scl_p      = scl_q[SYNC_STAGES];
  assign sda_s      = sda_q[SYNC_STAGES-1];
  assign sda_p      = sda_q[SYNC_STAGES];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_p;
  assign scl_fall_o = ~scl_s & scl_p;
  assign start_o    = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_o     = scl_s & scl_p & ~sda_p & sda_s;
endmodule

// File: rtl/dvi_iic_responder.sv
// dvi_iic_responder: I2C register-bus responder with auto-incrementing register pointer.
module dvi_iic_responder
  import dvi_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = CH7301_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       SCL,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);
  logic sda_s, scl_rise, scl_fall, start_p, stop_p;
  iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(Clk), .rst_n(Reset_n), .scl_i(SCL), .sda_i(SDA_in), .sda_o(sda_s),
    .scl_rise_o(scl_rise), .scl_fall_o(scl_fall), .start_o(start_p), .stop_o(stop_p)
  );
  iic_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, ptr_q, ptr_d, wa_q, wa_d, wd_q, wd_d;
  logic ack_q, ack_d, oe_q, oe_d, busy_q, busy_d, wv_q, wv_d;
  logic rx_st, match;
  assign rx_st = state_q inside {DEVADDR, REGADDR, WRDATA};
  assign match = (sh_q[7:1] == DEV_ADDR) && (sh_q[7:1] != 7'h00);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    ack_d   = ack_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    wv_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    if (stop_p) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_p) begin
      state_d = DEVADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (scl_rise) begin
      if (rx_st && cnt_q != 4'd8) begin
        sh_d  = {sh_q[6:0], sda_s};
        cnt_d = cnt_q + 4'd1;
      end
      // Bump the pointer at the ACK sample so rd_data is settled by the next scl_fall.
      if (state_q == RDACK) begin
        ack_d = sda_s;
        ptr_d = sda_s ? ptr_q : ptr_q + 8'd1;
      end
    end else if (scl_fall) begin
      case (state_q)
        DEVADDR: if (cnt_q == 4'd8) begin
          state_d = match ? DEVACK : IDLE;
          cnt_d   = '0;
          oe_d    = match;
          busy_d  = busy_q | match;
        end
        DEVACK: begin
          state_d = sh_q[0] ? RDDATA : REGADDR;
          oe_d    = sh_q[0] & ~rd_data[7];
          sh_d    = {rd_data[6:0], 1'b0};
          cnt_d   = sh_q[0] ? 4'd1 : 4'd0;
        end
        REGADDR: if (cnt_q == 4'd8) begin
          state_d = REGACK;
          ptr_d   = sh_q;
          oe_d    = 1'b1;
          cnt_d   = '0;
        end
        REGACK: begin
          state_d = WRDATA;
          oe_d    = 1'b0;
        end
        WRDATA: if (cnt_q == 4'd8) begin
          state_d = WRACK;
          wv_d    = 1'b1;
          wa_d    = ptr_q;
          wd_d    = sh_q;
          ptr_d   = ptr_q + 8'd1;
          oe_d    = 1'b1;
          cnt_d   = '0;
        end
        WRACK: begin
          state_d = WRDATA;
          oe_d    = 1'b0;
        end
        RDDATA: begin
          state_d = cnt_q == 4'd8 ? RDACK : RDDATA;
          oe_d    = cnt_q == 4'd8 ? 1'b0 : ~sh_q[7];
          sh_d    = {sh_q[6:0], 1'b0};
          cnt_d   = cnt_q == 4'd8 ? 4'd0 : cnt_q + 4'd1;
        end
        RDACK: begin
          state_d = ack_q ? IDLE : RDDATA;
          oe_d    = ~ack_q & ~rd_data[7];
          sh_d    = {rd_data[6:0], 1'b0};
          cnt_d   = 4'd1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      ack_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      wv_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      wv_q    <= wv_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end
  assign SDA_oe   = oe_q;
  assign wr_valid = wv_q;
  assign wr_addr  = wa_q;
  assign wr_data  = wd_q;
  assign rd_addr  = ptr_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_dvi_iic_responder.sv
// tb_dvi_iic_responder: directed I2C master transactions against the register-bus responder.
module tb_dvi_iic_responder;
  localparam int Q = 6;
  logic Clk = 1'b0, Reset_n = 1'b1, SCL = 1'b1, sda_m = 1'b1;
  logic SDA_in, SDA_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  int checks = 0, failures = 0, oe_cnt = 0;
  logic [15:0] wlog[$];
  always #5 Clk = ~Clk;
  assign SDA_in  = sda_m & ~SDA_oe;
  assign rd_data = rd_addr ^ 8'hDF;
  dvi_iic_responder dut (
    .Clk(Clk), .Reset_n(Reset_n), .SCL(SCL), .SDA_in(SDA_in), .SDA_oe(SDA_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );
  always @(negedge Clk) begin
    if (SDA_oe) oe_cnt++;
    if (wr_valid) wlog.push_back({wr_addr, wr_data});
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic q();
    repeat (Q) @(negedge Clk);
  endtask
  task automatic bit_io(input logic b, output logic r);
    sda_m = b; q(); SCL = 1'b1; q(); r = SDA_in; SCL = 1'b0; q();
  endtask
  task automatic xfer(input logic [7:0] tx, input logic b9, output logic [7:0] rx, output logic r9);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(tx[i], r);
      rx[i] = r;
    end
    bit_io(b9, r9);
  endtask
  task automatic start_c();
    sda_m = 1'b1; q(); SCL = 1'b1; q(); sda_m = 1'b0; q(); SCL = 1'b0; q();
  endtask
  task automatic stop_c();
    sda_m = 1'b0; q(); SCL = 1'b1; q(); sda_m = 1'b1; q();
  endtask
  initial begin
    logic [7:0] rx;
    logic a, r;
    int n0, o0;
    #2 Reset_n = 1'b0;
    #2;
    chk("rst_oe", SDA_oe, 1'b0);
    chk("rst_wv", wr_valid, 1'b0);
    chk("rst_waddr", wr_addr, 8'h00);
    chk("rst_wdata", wr_data, 8'h00);
    chk("rst_rdaddr", rd_addr, 8'h00);
    chk("rst_busy", busy, 1'b0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    n0 = wlog.size();
    start_c();
    xfer(8'hEC, 1'b1, rx, a); chk("w1_devack", a, 1'b0);
    chk("w1_busy", busy, 1'b1);
    xfer(8'h49, 1'b1, rx, a); chk("w1_regack", a, 1'b0);
    xfer(8'hC0, 1'b1, rx, a); chk("w1_dataack", a, 1'b0);
    chk("w1_count", wlog.size(), n0 + 1);
    chk("w1_entry", wlog[n0], 16'h49C0);
    chk("w1_ptr", rd_addr, 8'h4A);
    stop_c();
    chk("w1_busy_off", busy, 1'b0);
    n0 = wlog.size();
    start_c();
    xfer(8'hEC, 1'b1, rx, a); chk("w2_devack", a, 1'b0);
    xfer(8'hFE, 1'b1, rx, a); chk("w2_regack", a, 1'b0);
    xfer(8'h11, 1'b1, rx, a); chk("w2_ack1", a, 1'b0);
    xfer(8'h22, 1'b1, rx, a); chk("w2_ack2", a, 1'b0);
    xfer(8'h33, 1'b1, rx, a); chk("w2_ack3", a, 1'b0);
    stop_c();
    chk("w2_count", wlog.size(), n0 + 3);
    chk("w2_e0", wlog[n0], 16'hFE11);
    chk("w2_e1", wlog[n0+1], 16'hFF22);
    chk("w2_e2", wlog[n0+2], 16'h0033);
    chk("w2_ptr", rd_addr, 8'h01);
    start_c();
    xfer(8'hEC, 1'b1, rx, a); chk("r1_devack_w", a, 1'b0);
    xfer(8'h4A, 1'b1, rx, a); chk("r1_regack", a, 1'b0);
    start_c();
    xfer(8'hED, 1'b1, rx, a); chk("r1_devack_r", a, 1'b0);
    xfer(8'hFF, 1'b1, rx, a); chk("r1_data", rx, 8'h95);
    chk("r1_released", SDA_oe, 1'b0);
    chk("r1_ptr_hold", rd_addr, 8'h4A);
    o0 = oe_cnt;
    xfer(8'hFF, 1'b1, rx, a);
    chk("r1_idle_nodrive", oe_cnt, o0);
    stop_c();
    chk("r1_busy_off", busy, 1'b0);
    start_c();
    xfer(8'hED, 1'b1, rx, a); chk("r2_devack", a, 1'b0);
    xfer(8'hFF, 1'b0, rx, a); chk("r2_data0", rx, 8'h95);
    chk("r2_ptr_inc", rd_addr, 8'h4B);
    xfer(8'hFF, 1'b1, rx, a); chk("r2_data1", rx, 8'h94);
    stop_c();
    n0 = wlog.size();
    o0 = oe_cnt;
    start_c();
    xfer(8'hEA, 1'b1, rx, a); chk("m_nack", a, 1'b1);
    xfer(8'h10, 1'b1, rx, a); chk("m_nack2", a, 1'b1);
    stop_c();
    start_c();
    xfer(8'h00, 1'b1, rx, a); chk("gc_nack", a, 1'b1);
    stop_c();
    chk("m_no_oe", oe_cnt, o0);
    chk("m_no_wv", wlog.size(), n0);
    chk("m_busy", busy, 1'b0);
    start_c();
    xfer(8'hEC, 1'b1, rx, a); chk("p_devack", a, 1'b0);
    xfer(8'h20, 1'b1, rx, a); chk("p_regack", a, 1'b0);
    n0 = wlog.size();
    bit_io(1'b1, r); bit_io(1'b0, r); bit_io(1'b1, r); bit_io(1'b0, r);
    stop_c();
    chk("p_no_wv", wlog.size(), n0);
    chk("p_busy", busy, 1'b0);
    o0 = oe_cnt;
    SCL = 1'b0; q();
    xfer(8'h55, 1'b1, rx, a); chk("p_idle_nack", a, 1'b1);
    chk("p_idle_no_oe", oe_cnt, o0);
    start_c();
    xfer(8'hEC, 1'b1, rx, a);
    xfer(8'h4A, 1'b1, rx, a);
    start_c();
    xfer(8'hED, 1'b1, rx, a); chk("ar_devack", a, 1'b0);
    bit_io(1'b1, r); bit_io(1'b1, r); bit_io(1'b1, r); bit_io(1'b1, r);
    chk("ar_pre_oe", SDA_oe, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    chk("ar_oe", SDA_oe, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_rdaddr", rd_addr, 8'h00);
    chk("ar_wv", wr_valid, 1'b0);
    chk("ar_waddr", wr_addr, 8'h00);
    chk("ar_wdata", wr_data, 8'h00);
    SCL = 1'b1;
    sda_m = 1'b1;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    start_c();
    xfer(8'hEC, 1'b1, rx, a); chk("post_devack", a, 1'b0);
    xfer(8'h10, 1'b1, rx, a); chk("post_regack", a, 1'b0);
    stop_c();
    chk("post_ptr", rd_addr, 8'h10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
